// File: rtl/arm_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// arm_ctrl_pipe
// Control path of a small ARM pipeline. The ID-stage instruction word is
// decoded into control signals and a three-character mnemonic. The decoded
// controls can be swapped for an all-zero NOP bubble before they enter the
// ID/EX register. A subset of them then moves on into the EX/MEM register.
//
// Ports
//   Clk                     rising-edge clock for both pipeline registers
//   Reset                   synchronous active-high clear of ID/EX and EX/MEM
//   ID_instruction [31:0]   instruction word currently in ID
//   select                  1 = load a bubble into ID/EX, 0 = load the decode
//   ID_*                    combinational decode; never affected by select/Reset
//   ID_mnemonic0..2 [7:0]   ASCII mnemonic, char 0 is the leftmost character
//   EX_*                    ID/EX register outputs (1 cycle after ID)
//   MEM_*                   EX/MEM register outputs (2 cycles after ID)
// ---------------------------------------------------------------------------
module arm_ctrl_pipe (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ID_instruction,
  input  logic        select,
  output logic        ID_S_bit,
  output logic        ID_load_instr,
  output logic        ID_RF_enable,
  output logic        ID_B_instr,
  output logic        ID_load_store_instr,
  output logic        ID_size,
  output logic        ID_BL_instr,
  output logic [1:0]  ID_shift_AM,
  output logic [3:0]  ID_alu_op,
  output logic [7:0]  ID_mnemonic0,
  output logic [7:0]  ID_mnemonic1,
  output logic [7:0]  ID_mnemonic2,
  output logic        EX_S_instr,
  output logic        EX_load_instr,
  output logic        EX_RF_enable,
  output logic        EX_load_store_instr,
  output logic        EX_size,
  output logic        EX_BL_instr,
  output logic        EX_B_instr,
  output logic [1:0]  EX_shift_AM,
  output logic [3:0]  EX_alu_op,
  output logic        MEM_load_instr,
  output logic        MEM_load_store_instr,
  output logic        MEM_size,
  output logic        MEM_RF_enable
);

  // Control bundle carried through ID/EX.
  typedef struct packed {
    logic       s;
    logic       load;
    logic       rf;
    logic       ls;
    logic       size;
    logic       bl;
    logic       b;
    logic [1:0] am;
    logic [3:0] alu;
  } exCtrl_t;

  // Control bundle carried through EX/MEM.
  typedef struct packed {
    logic load;
    logic ls;
    logic size;
    logic rf;
  } memCtrl_t;

  logic [2:0]  instrClass;
  logic [3:0]  dpOpcode;
  logic [23:0] idMnem;
  logic [23:0] dpMnem;
  exCtrl_t     exCtrl_d, exCtrl_q;
  memCtrl_t    memCtrl_d, memCtrl_q;

  // The condition field [31:28] plays no part in the decode.
  assign instrClass = ID_instruction[27:25];
  assign dpOpcode   = ID_instruction[24:21];

  // Data-processing mnemonic table indexed by opcode.
  always_comb begin
    dpMnem = "???";
    case (dpOpcode)
      4'h0: dpMnem = "AND";
      4'h1: dpMnem = "EOR";
      4'h2: dpMnem = "SUB";
      4'h3: dpMnem = "RSB";
      4'h4: dpMnem = "ADD";
      4'h5: dpMnem = "ADC";
      4'h6: dpMnem = "SBC";
      4'h7: dpMnem = "RSC";
      4'h8: dpMnem = "TST";
      4'h9: dpMnem = "TEQ";
      4'hA: dpMnem = "CMP";
      4'hB: dpMnem = "CMN";
      4'hC: dpMnem = "ORR";
      4'hD: dpMnem = "MOV";
      4'hE: dpMnem = "BIC";
      4'hF: dpMnem = "MVN";
      default: dpMnem = "???";
    endcase
  end

  // Instruction decode. The all-zero word is a NOP; without this check it
  // would decode as AND in the register-operand data-processing class.
  always_comb begin
    ID_S_bit            = 1'b0;
    ID_load_instr       = 1'b0;
    ID_RF_enable        = 1'b0;
    ID_B_instr          = 1'b0;
    ID_load_store_instr = 1'b0;
    ID_size             = 1'b0;
    ID_BL_instr         = 1'b0;
    ID_shift_AM         = 2'b00;
    ID_alu_op           = 4'b0000;
    idMnem              = "???";
    if (ID_instruction == 32'h0) begin
      idMnem = "NOP";
    end else begin
      case (instrClass)
        3'b000, 3'b001: begin
          ID_alu_op    = dpOpcode;
          ID_S_bit     = ID_instruction[20];
          ID_shift_AM  = (instrClass == 3'b000) ? 2'b01 : 2'b00;
          // TST/TEQ/CMP/CMN only set flags and do not write a register.
          ID_RF_enable = (dpOpcode[3:2] != 2'b10);
          idMnem       = dpMnem;
        end
        3'b010, 3'b011: begin
          ID_load_store_instr = 1'b1;
          ID_load_instr       = ID_instruction[20];
          ID_size             = ID_instruction[22];
          // The U bit selects whether the offset is added or subtracted.
          ID_alu_op           = ID_instruction[23] ? 4'b0100 : 4'b0010;
          ID_shift_AM         = (instrClass == 3'b010) ? 2'b10 : 2'b11;
          ID_RF_enable        = ID_instruction[20];
          idMnem              = ID_instruction[20] ? "LDR" : "STR";
        end
        3'b101: begin
          ID_B_instr   = 1'b1;
          ID_BL_instr  = ID_instruction[24];
          // BL writes the return address to the link register.
          ID_RF_enable = ID_instruction[24];
          ID_alu_op    = 4'b0100;
          idMnem       = ID_instruction[24] ? "BL " : "B  ";
        end
        default: begin
          idMnem = "???";
        end
      endcase
    end
  end

  assign ID_mnemonic0 = idMnem[23:16];
  assign ID_mnemonic1 = idMnem[15:8];
  assign ID_mnemonic2 = idMnem[7:0];

  // Bubble mux in front of ID/EX. The ID outputs keep showing the raw decode.
  always_comb begin
    exCtrl_d = '0;
    if (!select) begin
      exCtrl_d.s    = ID_S_bit;
      exCtrl_d.load = ID_load_instr;
      exCtrl_d.rf   = ID_RF_enable;
      exCtrl_d.ls   = ID_load_store_instr;
      exCtrl_d.size = ID_size;
      exCtrl_d.bl   = ID_BL_instr;
      exCtrl_d.b    = ID_B_instr;
      exCtrl_d.am   = ID_shift_AM;
      exCtrl_d.alu  = ID_alu_op;
    end
  end

  // EX/MEM only keeps the controls that memory access and writeback need.
  always_comb begin
    memCtrl_d.load = exCtrl_q.load;
    memCtrl_d.ls   = exCtrl_q.ls;
    memCtrl_d.size = exCtrl_q.size;
    memCtrl_d.rf   = exCtrl_q.rf;
  end

  // Both registers load on every edge. Reset flushes both stages at once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      exCtrl_q  <= '0;
      memCtrl_q <= '0;
    end else begin
      exCtrl_q  <= exCtrl_d;
      memCtrl_q <= memCtrl_d;
    end
  end

  assign EX_S_instr          = exCtrl_q.s;
  assign EX_load_instr       = exCtrl_q.load;
  assign EX_RF_enable        = exCtrl_q.rf;
  assign EX_load_store_instr = exCtrl_q.ls;
  assign EX_size             = exCtrl_q.size;
  assign EX_BL_instr         = exCtrl_q.bl;
  assign EX_B_instr          = exCtrl_q.b;
  assign EX_shift_AM         = exCtrl_q.am;
  assign EX_alu_op           = exCtrl_q.alu;

  assign MEM_load_instr       = memCtrl_q.load;
  assign MEM_load_store_instr = memCtrl_q.ls;
  assign MEM_size             = memCtrl_q.size;
  assign MEM_RF_enable        = memCtrl_q.rf;

endmodule

// File: tb/tb_arm_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_arm_ctrl_pipe
// Self-checking bench for arm_ctrl_pipe. A behavioural model decodes each
// instruction word with plain arithmetic and tracks the two pipeline stages
// as simple variables. Directed vectors come first, then random traffic with
// random bubbles and occasional mid-stream resets.
// ---------------------------------------------------------------------------
module tb_arm_ctrl_pipe;

  logic        Clk;
  logic        Reset;
  logic [31:0] ID_instruction;
  logic        select;
  logic        ID_S_bit, ID_load_instr, ID_RF_enable, ID_B_instr;
  logic        ID_load_store_instr, ID_size, ID_BL_instr;
  logic [1:0]  ID_shift_AM;
  logic [3:0]  ID_alu_op;
  logic [7:0]  ID_mnemonic0, ID_mnemonic1, ID_mnemonic2;
  logic        EX_S_instr, EX_load_instr, EX_RF_enable, EX_load_store_instr;
  logic        EX_size, EX_BL_instr, EX_B_instr;
  logic [1:0]  EX_shift_AM;
  logic [3:0]  EX_alu_op;
  logic        MEM_load_instr, MEM_load_store_instr, MEM_size, MEM_RF_enable;

  int checks = 0;
  int errors = 0;

  arm_ctrl_pipe dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .ID_instruction      (ID_instruction),
    .select              (select),
    .ID_S_bit            (ID_S_bit),
    .ID_load_instr       (ID_load_instr),
    .ID_RF_enable        (ID_RF_enable),
    .ID_B_instr          (ID_B_instr),
    .ID_load_store_instr (ID_load_store_instr),
    .ID_size             (ID_size),
    .ID_BL_instr         (ID_BL_instr),
    .ID_shift_AM         (ID_shift_AM),
    .ID_alu_op           (ID_alu_op),
    .ID_mnemonic0        (ID_mnemonic0),
    .ID_mnemonic1        (ID_mnemonic1),
    .ID_mnemonic2        (ID_mnemonic2),
    .EX_S_instr          (EX_S_instr),
    .EX_load_instr       (EX_load_instr),
    .EX_RF_enable        (EX_RF_enable),
    .EX_load_store_instr (EX_load_store_instr),
    .EX_size             (EX_size),
    .EX_BL_instr         (EX_BL_instr),
    .EX_B_instr          (EX_B_instr),
    .EX_shift_AM         (EX_shift_AM),
    .EX_alu_op           (EX_alu_op),
    .MEM_load_instr      (MEM_load_instr),
    .MEM_load_store_instr(MEM_load_store_instr),
    .MEM_size            (MEM_size),
    .MEM_RF_enable       (MEM_RF_enable)
  );

  // 10-unit clock period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference control record. Packed order for comparison:
  // {s, load, rf, b, ls, size, bl, am[1:0], alu[3:0]}.
  typedef struct {
    bit       s, ld, rf, b, ls, sz, bl;
    bit [1:0] am;
    bit [3:0] alu;
    string    mn;
  } ctrl_t;

  string dpNames [16] = '{"AND", "EOR", "SUB", "RSB", "ADD", "ADC", "SBC", "RSC",
                          "TST", "TEQ", "CMP", "CMN", "ORR", "MOV", "BIC", "MVN"};

  ctrl_t expEx;
  ctrl_t expId;
  bit [3:0] expMem;

  function automatic ctrl_t zeroCtrl(input string mn);
    ctrl_t c;
    c.s = 0; c.ld = 0; c.rf = 0; c.b = 0; c.ls = 0; c.sz = 0; c.bl = 0;
    c.am = 0; c.alu = 0; c.mn = mn;
    return c;
  endfunction

  // Decode from the architectural rules using shifts and masks.
  function automatic ctrl_t refDecode(input bit [31:0] w);
    ctrl_t c;
    int cls, op;
    bit b20, b22, b23, b24;
    cls = int'((w >> 25) & 32'd7);
    op  = int'((w >> 21) & 32'd15);
    b20 = w[20]; b22 = w[22]; b23 = w[23]; b24 = w[24];
    c = zeroCtrl("???");
    if (w == 0) return zeroCtrl("NOP");
    if (cls == 0 || cls == 1) begin
      c.alu = 4'(op);
      c.s   = b20;
      c.am  = (cls == 0) ? 2'd1 : 2'd0;
      c.rf  = !(op >= 8 && op <= 11);
      c.mn  = dpNames[op];
    end else if (cls == 2 || cls == 3) begin
      c.ls  = 1;
      c.ld  = b20;
      c.sz  = b22;
      c.alu = b23 ? 4'd4 : 4'd2;
      c.am  = (cls == 2) ? 2'd2 : 2'd3;
      c.rf  = b20;
      c.mn  = b20 ? "LDR" : "STR";
    end else if (cls == 5) begin
      c.b   = 1;
      c.bl  = b24;
      c.rf  = b24;
      c.alu = 4'd4;
      c.mn  = b24 ? "BL " : "B  ";
    end
    return c;
  endfunction

  function automatic bit [12:0] packCtrl(input ctrl_t c);
    return {c.s, c.ld, c.rf, c.b, c.ls, c.sz, c.bl, c.am, c.alu};
  endfunction

  function automatic bit [23:0] packMnem(input string mn);
    bit [7:0] c0, c1, c2;
    c0 = mn[0]; c1 = mn[1]; c2 = mn[2];
    return {c0, c1, c2};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkId();
    checkOutput("ID_ctrl", 32'({ID_S_bit, ID_load_instr, ID_RF_enable, ID_B_instr,
                                ID_load_store_instr, ID_size, ID_BL_instr,
                                ID_shift_AM, ID_alu_op}),
                32'(packCtrl(expId)));
    checkOutput("ID_mnem", 32'({ID_mnemonic0, ID_mnemonic1, ID_mnemonic2}),
                32'(packMnem(expId.mn)));
  endtask

  task automatic checkRegs();
    checkOutput("EX_ctrl", 32'({EX_S_instr, EX_load_instr, EX_RF_enable, EX_B_instr,
                                EX_load_store_instr, EX_size, EX_BL_instr,
                                EX_shift_AM, EX_alu_op}),
                32'(packCtrl(expEx)));
    checkOutput("MEM_ctrl", 32'({MEM_load_instr, MEM_load_store_instr, MEM_size,
                                 MEM_RF_enable}),
                32'(expMem));
  endtask

  // One cycle: drive inputs, check the decode, clock, advance the model,
  // then check both pipeline stages just after the edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic sel,
                               input logic rst);
    ID_instruction = instr;
    select         = sel;
    Reset          = rst;
    expId          = refDecode(instr);
    #1;
    checkId();
    @(posedge Clk);
    if (rst) begin
      expMem = 0;
      expEx  = zeroCtrl("");
    end else begin
      expMem = {expEx.ld, expEx.ls, expEx.sz, expEx.rf};
      expEx  = sel ? zeroCtrl("") : expId;
    end
    #1;
    checkRegs();
  endtask

  initial begin
    logic [31:0] w;
    ID_instruction = 32'h0;
    select         = 1'b0;
    Reset          = 1'b0;
    expEx          = zeroCtrl("");
    expMem         = 0;
    @(posedge Clk);
    #1;

    // Reset with a live instruction: ID must still decode it.
    applyStimulus(32'hE0810002, 1'b0, 1'b1);
    // Directed sequence.
    applyStimulus(32'hE0810002, 1'b0, 1'b0);   // ADD r0,r1,r2
    applyStimulus(32'hE3530000, 1'b0, 1'b0);   // CMP r3,#0
    applyStimulus(32'hE5D12004, 1'b0, 1'b0);   // LDRB r2,[r1,#4]
    applyStimulus(32'hE5012004, 1'b0, 1'b0);   // STR r2,[r1,#-4]
    applyStimulus(32'hEBFFFFFE, 1'b0, 1'b0);   // BL
    applyStimulus(32'hEBFFFFFE, 1'b1, 1'b0);   // BL with bubble
    applyStimulus(32'hEAFFFFFE, 1'b0, 1'b0);   // B
    applyStimulus(32'h00000000, 1'b0, 1'b0);   // NOP
    applyStimulus(32'hE8900003, 1'b0, 1'b0);   // class 100 -> ???
    applyStimulus(32'hE7912003, 1'b0, 1'b0);   // LDR register offset
    applyStimulus(32'hE1B00001, 1'b0, 1'b0);   // MOVS (TST range excluded)
    applyStimulus(32'hE5D12004, 1'b0, 1'b1);   // mid-stream reset flush
    applyStimulus(32'hE5D12004, 1'b0, 1'b0);

    // Random traffic with random bubbles and rare resets.
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w = 32'h0;
      applyStimulus(w, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
